hwpe_stream_sink_2d: RTL and testbench

Parametrised multi-port store streamer for HWPE engines. It consumes a HWPE-Stream of `DATA_WIDTH`-bit beats and writes them to memory through `NB_TCDM_PORTS` independent 32-bit HWPE-Mem ports. Addresses follow a 2D pattern (lines of words with a signed line stride) produced by a built-in address generator. Compared with the previous sink generation it adds:

- per-port independent grant handling;
- suppression of fully-masked words;
- a drain phase before `done`;
- a progress counter.

---
 rtl/hwpe_stream_sink_2d.sv | 176 +++++++++++++++++
 tb/tb_hwpe_stream_sink_2d.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_sink_2d.sv
`default_nettype none
// ============================================================================
// Module : hwpe_stream_sink_2d
// Brief  : Store streamer writing a HWPE-Stream to memory through independent
//          32-bit ports along a 2D (line/stride) address pattern.
// Rev    : 1.0
// ============================================================================
module hwpe_stream_sink_2d #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                req_start_i,
    input  logic [ADDR_WIDTH-1:0]               base_addr_i,
    input  logic [CNT_WIDTH-1:0]                line_len_i,
    input  logic [CNT_WIDTH-1:0]                nb_lines_i,
    input  logic [ADDR_WIDTH-1:0]               line_stride_i,
    input  logic                                stream_valid_i,
    input  logic [DATA_WIDTH-1:0]               stream_data_i,
    input  logic [DATA_WIDTH/8-1:0]             stream_strb_i,
    output logic                                stream_ready_o,
    output logic [NB_TCDM_PORTS-1:0]            tcdm_req_o,
    input  logic [NB_TCDM_PORTS-1:0]            tcdm_gnt_i,
    output logic [NB_TCDM_PORTS*ADDR_WIDTH-1:0] tcdm_add_o,
    output logic [NB_TCDM_PORTS*32-1:0]         tcdm_data_o,
    output logic [NB_TCDM_PORTS*4-1:0]          tcdm_be_o,
    output logic [NB_TCDM_PORTS-1:0]            tcdm_wen_o,
    output logic                                ready_start_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [2*CNT_WIDTH-1:0]              beats_done_o
);

    localparam logic [ADDR_WIDTH-1:0] c_beat_bytes = ADDR_WIDTH'(NB_TCDM_PORTS * 4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WORKING = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e                     r_state, w_state_nxt;
    logic                       r_done, w_done_nxt;
    logic [NB_TCDM_PORTS-1:0]   r_pending;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [DATA_WIDTH/8-1:0]    r_be;
    logic [ADDR_WIDTH-1:0]      r_beat_addr;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [ADDR_WIDTH-1:0]      r_line_base;
    logic [ADDR_WIDTH-1:0]      r_stride;
    logic [CNT_WIDTH-1:0]       r_line_len;
    logic [CNT_WIDTH-1:0]       r_nb_lines;
    logic [CNT_WIDTH-1:0]       r_word;
    logic [CNT_WIDTH-1:0]       r_line;
    logic [2*CNT_WIDTH-1:0]     r_beats;

    logic                       w_stall;
    logic                       w_accept;
    logic                       w_line_end;
    logic                       w_last_beat;
    logic [NB_TCDM_PORTS-1:0]   w_strb_nz;

    // A port still waiting for its grant blocks the next beat from overwriting the buffer.
    assign w_stall        = |(r_pending & ~tcdm_gnt_i);
    assign stream_ready_o = (r_state == ST_WORKING) && !w_stall;
    assign w_accept       = stream_valid_i && stream_ready_o;
    assign w_line_end     = (r_word == r_line_len - CNT_WIDTH'(1));
    assign w_last_beat    = w_line_end && (r_line == r_nb_lines - CNT_WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_start_i) begin
                    if ((line_len_i == '0) || (nb_lines_i == '0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WORKING;
                    end
                end
            end
            ST_WORKING: begin
                // A fully masked last beat has nothing to drain.
                if (w_accept && w_last_beat) begin
                    if (w_strb_nz == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_stall) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_pending   <= '0;
            r_data      <= '0;
            r_be        <= '0;
            r_beat_addr <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_stride    <= '0;
            r_line_len  <= '0;
            r_nb_lines  <= '0;
            r_word      <= '0;
            r_line      <= '0;
            r_beats     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_pending <= r_pending & ~tcdm_gnt_i;
            if ((r_state == ST_IDLE) && req_start_i) begin
                r_line_base <= base_addr_i & ~ADDR_WIDTH'(3);
                r_addr      <= base_addr_i & ~ADDR_WIDTH'(3);
                r_stride    <= line_stride_i;
                r_line_len  <= line_len_i;
                r_nb_lines  <= nb_lines_i;
                r_word      <= '0;
                r_line      <= '0;
                r_beats     <= '0;
            end
            if (w_accept) begin
                r_pending   <= w_strb_nz;
                r_data      <= stream_data_i;
                r_be        <= stream_strb_i;
                r_beat_addr <= r_addr;
                r_beats     <= r_beats + (2*CNT_WIDTH)'(1);
                if (w_line_end) begin
                    r_word      <= '0;
                    r_line_base <= r_line_base + r_stride;
                    r_addr      <= r_line_base + r_stride;
                    r_line      <= r_line + CNT_WIDTH'(1);
                end else begin
                    r_word <= r_word + CNT_WIDTH'(1);
                    r_addr <= r_addr + c_beat_bytes;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_port
            assign w_strb_nz[i] = |stream_strb_i[i*4 +: 4];
            assign tcdm_add_o[i*ADDR_WIDTH +: ADDR_WIDTH] =
                r_pending[i] ? (r_beat_addr + ADDR_WIDTH'(4*i)) : '0;
            assign tcdm_data_o[i*32 +: 32] = r_pending[i] ? r_data[i*32 +: 32] : '0;
            assign tcdm_be_o[i*4 +: 4]     = r_pending[i] ? r_be[i*4 +: 4] : '0;
        end
    endgenerate

    assign tcdm_req_o    = r_pending;
    assign tcdm_wen_o    = '0;
    assign ready_start_o = (r_state == ST_IDLE);
    assign busy_o        = (r_state == ST_WORKING) || (r_state == ST_DRAIN);
    assign done_o        = r_done;
    assign beats_done_o  = r_beats;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_sink_2d.sv
`default_nettype none
// ============================================================================
// Module : tb_hwpe_stream_sink_2d
// Brief  : Self-checking bench for hwpe_stream_sink_2d (job table, random
//          stream/grants, expected-write queues per port).
// Rev    : 1.0
// ============================================================================
module tb_hwpe_stream_sink_2d;

    localparam int DW = 64;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            req_start_i;
    logic [AW-1:0]   base_addr_i;
    logic [CW-1:0]   line_len_i;
    logic [CW-1:0]   nb_lines_i;
    logic [AW-1:0]   line_stride_i;
    logic            stream_valid_i;
    logic [DW-1:0]   stream_data_i;
    logic [DW/8-1:0] stream_strb_i;
    logic            stream_ready_o;
    logic [NP-1:0]   tcdm_req_o;
    logic [NP-1:0]   tcdm_gnt_i;
    logic [NP*AW-1:0] tcdm_add_o;
    logic [NP*32-1:0] tcdm_data_o;
    logic [NP*4-1:0]  tcdm_be_o;
    logic [NP-1:0]   tcdm_wen_o;
    logic            ready_start_o;
    logic            busy_o;
    logic            done_o;
    logic [2*CW-1:0] beats_done_o;

    always #5 clk = ~clk;

    hwpe_stream_sink_2d #(
        .DATA_WIDTH(DW), .NB_TCDM_PORTS(NP), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .req_start_i(req_start_i),
        .base_addr_i(base_addr_i), .line_len_i(line_len_i), .nb_lines_i(nb_lines_i),
        .line_stride_i(line_stride_i), .stream_valid_i(stream_valid_i),
        .stream_data_i(stream_data_i), .stream_strb_i(stream_strb_i),
        .stream_ready_o(stream_ready_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_add_o(tcdm_add_o), .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_wen_o(tcdm_wen_o), .ready_start_o(ready_start_o), .busy_o(busy_o),
        .done_o(done_o), .beats_done_o(beats_done_o)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // gmode: 0 grants always, 1 random grants and valid gaps, 2 port 1 withheld 3 cycles on beat 0
    // smode: 0 full strobes, 1 random strobes (last full), 3 beat 1 = 0x0F and last beat = 0
    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        logic [15:0] lines;
        logic [31:0] stride;
        int          gmode;
        int          smode;
        int          exp_beats;
        bit          chk_last;
        logic [31:0] exp_last;
    } job_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } wr_t;

    task automatic run_job(input job_t j, input string tag);
        logic [63:0] sd[$];
        logic [7:0]  ss[$];
        wr_t         q[NP][$];
        wr_t         e;
        logic [31:0] addr, last_p0;
        logic [63:0] d;
        logic [7:0]  s;
        int total, idx, hold1;
        bit armed, finished, early, acc;

        total = int'(j.len) * int'(j.lines);
        for (int l = 0; l < int'(j.lines); l++) begin
            for (int w = 0; w < int'(j.len); w++) begin
                addr = (j.base & ~32'h3) + 32'(l) * j.stride + 32'(w * 8);
                d = {$urandom, $urandom};
                case (j.smode)
                    1: begin
                        s = 8'($urandom);
                        if ($urandom_range(0, 3) == 0) s[3:0] = 4'h0;
                        if ($urandom_range(0, 3) == 0) s[7:4] = 4'h0;
                        if (l * int'(j.len) + w == total - 1) s = 8'hFF;
                    end
                    3: begin
                        s = 8'hFF;
                        if (l * int'(j.len) + w == 1) s = 8'h0F;
                        if (l * int'(j.len) + w == total - 1) s = 8'h00;
                    end
                    default: s = 8'hFF;
                endcase
                sd.push_back(d);
                ss.push_back(s);
                for (int p = 0; p < NP; p++) begin
                    if (s[p*4 +: 4] != 4'h0) begin
                        e.a = addr + 32'(4 * p);
                        e.d = d[p*32 +: 32];
                        e.b = s[p*4 +: 4];
                        q[p].push_back(e);
                    end
                end
            end
        end

        @(posedge clk); #1;
        base_addr_i = j.base; line_len_i = j.len; nb_lines_i = j.lines;
        line_stride_i = j.stride; req_start_i = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_start"}, 64'(ready_start_o), 64'd1);
        @(posedge clk); #1;
        req_start_i = 1'b0;

        idx = 0; hold1 = 0; armed = 0; finished = 0; early = 0; acc = 0; last_p0 = '0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (!stream_valid_i || acc) begin
                if (idx < total && (j.gmode != 1 || $urandom_range(0, 3) != 0)) begin
                    stream_valid_i = 1'b1;
                    stream_data_i  = sd[idx];
                    stream_strb_i  = ss[idx];
                end else begin
                    stream_valid_i = 1'b0;
                end
            end
            case (j.gmode)
                1: tcdm_gnt_i = 2'($urandom_range(0, 3));
                2: begin
                    tcdm_gnt_i[0] = 1'b1;
                    tcdm_gnt_i[1] = 1'b1;
                    if (tcdm_req_o[1] && hold1 < 3) begin
                        tcdm_gnt_i[1] = 1'b0;
                        hold1++;
                    end
                end
                default: tcdm_gnt_i = 2'b11;
            endcase

            @(negedge clk);
            acc = 0;
            if (armed) begin
                chk({tag, "_done"}, 64'(done_o), 64'd1);
                chk({tag, "_beats_done"}, 64'(beats_done_o), 64'(j.exp_beats));
                chk({tag, "_end_ready_start"}, 64'(ready_start_o), 64'd1);
                chk({tag, "_end_busy"}, 64'(busy_o), 64'd0);
                chk({tag, "_end_req"}, 64'(tcdm_req_o), 64'd0);
                if (j.chk_last) chk({tag, "_last_p0_addr"}, 64'(last_p0), 64'(j.exp_last));
                finished = 1;
            end else begin
                if (done_o) early = 1;
                for (int p = 0; p < NP; p++) begin
                    if (tcdm_req_o[p]) begin
                        if (q[p].size() == 0) begin
                            chk($sformatf("%s_unexpected_req_p%0d", tag, p), 64'd1, 64'd0);
                        end else begin
                            chk($sformatf("%s_add_p%0d", tag, p), 64'(tcdm_add_o[p*AW +: AW]), 64'(q[p][0].a));
                            chk($sformatf("%s_data_p%0d", tag, p), 64'(tcdm_data_o[p*32 +: 32]), 64'(q[p][0].d));
                            chk($sformatf("%s_be_p%0d", tag, p), 64'(tcdm_be_o[p*4 +: 4]), 64'(q[p][0].b));
                            if (tcdm_gnt_i[p]) begin
                                if (p == 0) last_p0 = tcdm_add_o[AW-1:0];
                                void'(q[p].pop_front());
                            end
                        end
                    end else begin
                        chk($sformatf("%s_idle_p%0d", tag, p),
                            {tcdm_add_o[p*AW +: AW], tcdm_data_o[p*32 +: 32]} | 64'(tcdm_be_o[p*4 +: 4]), 64'd0);
                    end
                end
                if (j.gmode == 2 && tcdm_req_o[1] && !tcdm_gnt_i[1])
                    chk({tag, "_stall_ready"}, 64'(stream_ready_o), 64'd0);
                chk({tag, "_wen"}, 64'(tcdm_wen_o), 64'd0);
                if (stream_valid_i && stream_ready_o) begin
                    acc = 1;
                    idx++;
                end
                if (idx == total && q[0].size() == 0 && q[1].size() == 0) armed = 1;
            end
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_timeout"}, 64'(finished), 64'd1);
        chk({tag, "_early_done"}, 64'(early), 64'd0);
        stream_valid_i = 1'b0;
        tcdm_gnt_i = '0;
    endtask

    task automatic start_small(input logic [15:0] len, input logic [15:0] lines);
        @(posedge clk); #1;
        base_addr_i = 32'h300; line_len_i = len; nb_lines_i = lines;
        line_stride_i = 32'h0; req_start_i = 1'b1;
        @(posedge clk); #1;
        req_start_i = 1'b0;
    endtask

    // Accepts one full beat with grants withheld so both ports stay pending.
    task automatic one_beat_pending(input string tag);
        tcdm_gnt_i = '0;
        start_small(16'd4, 16'd1);
        stream_valid_i = 1'b1; stream_data_i = 64'hDEAD_BEEF_1234_5678; stream_strb_i = 8'hFF;
        @(posedge clk); #1;
        stream_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_pre_req"}, 64'(tcdm_req_o), 64'h3);
        chk({tag, "_pre_beats"}, 64'(beats_done_o), 64'd1);
    endtask

    job_t jobs[7];

    initial begin
        jobs[0] = '{32'h100, 16'd3, 16'd2, 32'h40, 0, 0, 6, 1'b1, 32'h150};
        jobs[1] = '{32'h100, 16'd3, 16'd2, 32'h40, 2, 0, 6, 1'b1, 32'h150};
        jobs[2] = '{32'h100, 16'd3, 16'd2, 32'h40, 0, 3, 6, 1'b0, 32'h0};
        jobs[3] = '{32'h0, 16'd1, 16'd2, 32'hFFFF_FFC0, 0, 0, 2, 1'b1, 32'hFFFF_FFC0};
        jobs[4] = '{32'hFFFF_FFF8, 16'd2, 16'd1, 32'h0, 0, 0, 2, 1'b1, 32'h0};
        jobs[5] = '{32'h1003, 16'd4, 16'd3, 32'h100, 1, 1, 12, 1'b1, 32'h1218};
        jobs[6] = '{32'h2000, 16'd5, 16'd3, 32'hFFFF_FF80, 1, 1, 15, 1'b1, 32'h1F20};

        rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0;
        base_addr_i = '0; line_len_i = '0; nb_lines_i = '0; line_stride_i = '0;
        stream_valid_i = 1'b0; stream_data_i = '0; stream_strb_i = '0; tcdm_gnt_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_start", 64'(ready_start_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_beats", 64'(beats_done_o), 64'd0);
        chk("rst_req", 64'(tcdm_req_o), 64'd0);
        chk("rst_stream_ready", 64'(stream_ready_o), 64'd0);
        chk("rst_tcdm_outs", tcdm_add_o | {tcdm_data_o[31:0], tcdm_data_o[63:32]} | 64'(tcdm_be_o), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) run_job(jobs[i], $sformatf("job%0d", i));

        start_small(16'd3, 16'd0);
        @(negedge clk);
        chk("zero_done", 64'(done_o), 64'd1);
        chk("zero_busy", 64'(busy_o), 64'd0);
        chk("zero_req", 64'(tcdm_req_o), 64'd0);
        chk("zero_ready_start", 64'(ready_start_o), 64'd1);
        @(negedge clk);
        chk("zero_done_pulse", 64'(done_o), 64'd0);

        one_beat_pending("clr");
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_req", 64'(tcdm_req_o), 64'd0);
        chk("clr_ready_start", 64'(ready_start_o), 64'd1);
        chk("clr_done", 64'(done_o), 64'd0);
        chk("clr_beats", 64'(beats_done_o), 64'd0);
        @(negedge clk);
        chk("clr_done_after", 64'(done_o), 64'd0);

        one_beat_pending("rst");
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 64'(tcdm_req_o), 64'd0);
        chk("rst_mid_ready_start", 64'(ready_start_o), 64'd1);
        chk("rst_mid_done", 64'(done_o), 64'd0);
        chk("rst_mid_beats", 64'(beats_done_o), 64'd0);

        run_job(jobs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
